// File: rtl/tt_minmax_stack.sv
// LIFO front-end for an external single-port synchronous RAM that tracks the running max and min.
// Each RAM word keeps {prev max, prev min, data}, so a pop restores both extremes with one read.
module tt_minmax_stack #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic            iclk,
  input  logic            ireset,
  output logic            oready,
  input  logic            ireq_valid,
  input  logic [1:0]      ireq_op,
  input  logic [DW-1:0]   ireq_push_data,
  output logic            oresp_valid,
  output logic [DW-1:0]   oresp_pop_data,
  output logic [1:0]      oresp_error_code,
  output logic            omax_data_valid,
  output logic [DW-1:0]   omax_data,
  output logic [DW-1:0]   omin_data,
  output logic [AW:0]     ocount,
  output logic [AW-1:0]   omem_addr,
  output logic [3*DW-1:0] omem_write_data,
  output logic            omem_write_enable,
  input  logic [3*DW-1:0] imem_read_data
);

  typedef enum logic [1:0] {StIdle, StPopRd, StPopWait} state_e;

  localparam logic [AW:0] Full = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] One  = (AW+1)'(1);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [AW:0]       count_q, count_d;
  logic [DW-1:0]     max_q, max_d, min_q, min_d;
  logic              valid_q, valid_d;
  logic              peek_q, peek_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DW-1:0]     resp_data_q, resp_data_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [3*DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              accept;
  logic [AW:0]       count_m1;
  logic [DW-1:0]     prev_max, prev_min;

  function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  // ready_q is only ever set while idle, so it doubles as the idle qualifier
  assign accept   = ireq_valid & ready_q;
  assign count_m1 = count_q - One;
  assign prev_max = valid_q ? max_q : '0;
  assign prev_min = valid_q ? min_q : '0;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    max_d        = max_q;
    min_d        = min_q;
    valid_d      = valid_q;
    peek_d       = peek_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (ireq_op)
            2'b00: begin
              resp_valid_d = 1'b1;
              resp_data_d  = '0;
              if (count_q == Full) begin
                resp_err_d = 2'd2;
              end else begin
                resp_err_d  = 2'd0;
                mem_we_d    = 1'b1;
                mem_addr_d  = count_q[AW-1:0];
                mem_wdata_d = {prev_max, prev_min, ireq_push_data};
                count_d     = count_q + One;
                valid_d     = 1'b1;
                if (!valid_q) begin
                  max_d = ireq_push_data;
                  min_d = ireq_push_data;
                end else begin
                  if (gt(ireq_push_data, max_q)) max_d = ireq_push_data;
                  if (gt(min_q, ireq_push_data)) min_d = ireq_push_data;
                end
              end
            end
            2'b01, 2'b10: begin
              if (count_q == '0) begin
                resp_valid_d = 1'b1;
                resp_data_d  = '0;
                resp_err_d   = 2'd1;
              end else begin
                state_d    = StPopRd;
                peek_d     = ireq_op[1];
                mem_addr_d = count_m1[AW-1:0];
              end
            end
            default: begin
              resp_valid_d = 1'b1;
              resp_data_d  = '0;
              resp_err_d   = 2'd0;
              count_d      = '0;
              valid_d      = 1'b0;
              max_d        = '0;
              min_d        = '0;
            end
          endcase
        end
      end
      StPopRd: state_d = StPopWait;
      StPopWait: begin
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_data_d  = imem_read_data[DW-1:0];
        resp_err_d   = 2'd0;
        if (!peek_q) begin
          count_d = count_m1;
          max_d   = imem_read_data[3*DW-1:2*DW];
          min_d   = imem_read_data[2*DW-1:DW];
          valid_d = (count_m1 != '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered ready stays low for the first cycle after reset release
  assign ready_d = (state_d == StIdle);

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      count_q      <= '0;
      max_q        <= '0;
      min_q        <= '0;
      valid_q      <= 1'b0;
      peek_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
      max_q        <= max_d;
      min_q        <= min_d;
      valid_q      <= valid_d;
      peek_q       <= peek_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign oready            = ready_q;
  assign oresp_valid       = resp_valid_q;
  assign oresp_pop_data    = resp_data_q;
  assign oresp_error_code  = resp_err_q;
  assign omax_data_valid   = valid_q;
  assign omax_data         = max_q;
  assign omin_data         = min_q;
  assign ocount            = count_q;
  assign omem_addr         = mem_addr_q;
  assign omem_write_data   = mem_wdata_q;
  assign omem_write_enable = mem_we_q;

endmodule
